// File: rtl/mult_issue.sv
// mult_issue: operand FIFO + issue sequencer in front of the sequential
// multiplier `mult`; captures its product into a valid/ready output register.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         operand pair handshake (in_multiplicand, in_multiplier)
//   out_valid/out_ready       product handshake (out_result, 2*WIDTH bits)
//   mult_multiplicand/_multiplier/_enable -> mult ; mult_done/_result <- mult
//   busy                      state not IDLE or FIFO non-empty
//   timeout_err               sticky: an operation was dropped by the watchdog
module mult_issue #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 127
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplicand,
  input  logic [WIDTH-1:0]   in_multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [WIDTH-1:0]   mult_multiplicand,
  output logic [WIDTH-1:0]   mult_multiplier,
  output logic               mult_enable,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_result,
  output logic               busy,
  output logic               timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   fa_q [DEPTH];
  logic [WIDTH-1:0]   fb_q [DEPTH];
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      wd_q, wd_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               ov_q, ov_d;
  logic               terr_q, terr_d;

  logic push, pop, empty, start, in_wait, wd_hit;

  // in_ready looks only at the count, so a same-cycle pop never
  // opens a slot while full.
  assign in_ready = (cnt_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign empty    = (cnt_q == '0);
  assign in_wait  = (state_q == WAIT);
  // wd_q counts completed WAIT cycles; this is the TIMEOUT-th one.
  assign wd_hit   = (wd_q == TW'(TIMEOUT - 1));
  assign pop      = in_wait && (mult_done || wd_hit);
  // Only start when the output register is free or being drained now.
  assign start    = (state_q == IDLE) && !empty && (!ov_q || out_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mult_done || wd_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mult_enable       = (state_q == ISSUE);
    mult_multiplicand = opa_q;
    mult_multiplier   = opb_q;
    out_valid         = ov_q;
    out_result        = res_q;
    timeout_err       = terr_q;
    busy              = (state_q != IDLE) || !empty;
  end

  // Datapath next-state
  always_comb begin
    wr_d   = push ? wr_q + AW'(1) : wr_q;
    rd_d   = pop  ? rd_q + AW'(1) : rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    opa_d  = start ? fa_q[rd_q] : opa_q;
    opb_d  = start ? fb_q[rd_q] : opb_q;
    wd_d   = wd_q;
    if (state_q == ISSUE) wd_d = '0;
    else if (in_wait)     wd_d = wd_q + TW'(1);
    ov_d   = ov_q && !out_ready;
    res_d  = res_q;
    if (in_wait && mult_done) begin
      ov_d  = 1'b1;
      res_d = mult_result;
    end
    // done wins over a simultaneous watchdog expiry
    terr_d = terr_q || (in_wait && !mult_done && wd_hit);
  end

  // FIFO storage needs no reset; the count qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wr_q] <= in_multiplicand;
      fb_q[wr_q] <= in_multiplier;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      wd_q   <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
      ov_q   <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      wd_q   <= wd_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      res_q  <= res_d;
      ov_q   <= ov_d;
      terr_q <= terr_d;
    end
  end

endmodule

// File: tb/tb_mult_issue.sv
// tb_mult_issue: directed vectors and hand sequences for mult_issue,
// with a behavioural latency model of the downstream multiplier.
module tb_mult_issue;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int TO = 127;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_multiplicand, in_multiplier;
  logic          out_valid, out_ready;
  logic [63:0]   out_result;
  logic [W-1:0]  mult_multiplicand, mult_multiplier;
  logic          mult_enable;
  logic          mult_done = 1'b0;
  logic [63:0]   mult_result = '0;
  logic          busy, timeout_err;

  mult_issue #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
    .mult_enable(mult_enable), .mult_done(mult_done),
    .mult_result(mult_result),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  // Multiplier model: done pulses `lat` cycles after the enable cycle.
  int          lat = 33;
  bit          hang = 0;
  bit          force_done = 0;
  bit          pend = 0;
  int          mcnt = 0;
  logic [63:0] prod = '0;
  int          en_cnt = 0;

  always @(negedge clk) begin
    mult_done = 1'b0;
    if (mult_enable) en_cnt++;
    if (force_done) begin
      mult_done   = 1'b1;
      mult_result = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (!hang) begin
      if (pend) begin
        if (mcnt <= 1) begin
          mult_done   = 1'b1;
          mult_result = prod;
          pend        = 0;
        end else begin
          mcnt--;
        end
      end
      if (mult_enable) begin
        pend = 1;
        mcnt = lat;
        prod = 64'(mult_multiplicand) * 64'(mult_multiplier);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid        = 1'b1;
    in_multiplicand = a;
    in_multiplier   = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int k);
    k = 0;
    while (!out_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           l;
    logic [63:0]  p;
  } vec_t;

  vec_t        tv [5];
  logic [W-1:0] fa [6];
  logic [W-1:0] fb [6];
  logic [63:0]  fp [6];

  initial begin
    int k, e0, pi, got;
    bit acc;

    tv[0] = '{32'd3, 32'd5, 33, 64'd15};
    tv[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'hFFFF_FFFE_0000_0001};
    tv[2] = '{32'd0, 32'h1234_5678, 33, 64'd0};
    tv[3] = '{32'h0001_0000, 32'h0001_0000, 1, 64'h1_0000_0000};
    // done lands on the watchdog's last WAIT cycle: done must win
    tv[4] = '{32'd13, 32'd3, TO, 64'd39};

    fa = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9, 32'd11};
    fb = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10, 32'd12};
    fp = '{64'd2, 64'd12, 64'd30, 64'd56, 64'd90, 64'd132};

    in_valid = 0;
    in_multiplicand = '0;
    in_multiplier = '0;
    out_ready = 0;

    #2;
    chk("rst_ov", out_valid, 0);
    chk("rst_en", mult_enable, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_res", out_result, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Table-driven single operations
    for (int i = 0; i < 5; i++) begin
      lat = tv[i].l;
      e0  = en_cnt;
      push(tv[i].a, tv[i].b);
      chk("en_n1", mult_enable, 0);
      @(negedge clk);
      chk("en_n2", mult_enable, 1);
      chk("opa", mult_multiplicand, tv[i].a);
      chk("opb", mult_multiplier, tv[i].b);
      @(negedge clk);
      chk("en_n3", mult_enable, 0);
      wait_ov(k);
      chk("lat", k, tv[i].l);
      chk("res", out_result, tv[i].p);
      chk("terr0", timeout_err, 0);
      @(negedge clk);
      chk("hold_v", out_valid, 1);
      chk("hold_r", out_result, tv[i].p);
      drain();
      chk("drained", out_valid, 0);
      chk("pulses", en_cnt - e0, 1);
      chk("idle", busy, 0);
    end

    // Fill with backpressure
    lat = 33;
    e0  = en_cnt;
    pi  = 0;
    for (int c = 0; c < 64; c++) begin
      acc = 0;
      in_valid = 0;
      if (pi < 6) begin
        in_valid = 1;
        in_multiplicand = fa[pi];
        in_multiplier = fb[pi];
        acc = in_ready;
      end
      @(negedge clk);
      if (acc) pi++;
      if (c == 3) begin
        chk("full_pi", pi, 4);
        chk("full_rdy", in_ready, 0);
      end
    end
    chk("one_pulse", en_cnt - e0, 1);
    chk("bp_ov", out_valid, 1);
    chk("bp_head", out_result, fp[0]);

    out_ready = 1;
    got = 0;
    for (int c = 0; c < 2000 && got < 6; c++) begin
      acc = 0;
      in_valid = 0;
      if (pi < 6) begin
        in_valid = 1;
        in_multiplicand = fa[pi];
        in_multiplier = fb[pi];
        acc = in_ready;
      end
      if (out_valid) begin
        chk("order", out_result, fp[got]);
        got++;
      end
      @(negedge clk);
      if (acc) pi++;
    end
    in_valid = 0;
    out_ready = 0;
    chk("got_all", got, 6);
    @(negedge clk);
    chk("fill_idle", busy, 0);

    // Watchdog: first op never completes, second completes
    hang = 1;
    push(32'd2, 32'd3);
    push(32'd4, 32'd5);
    k = 0;
    while (!timeout_err && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", k, TO + 1);
    chk("to_ov", out_valid, 0);
    hang = 0;
    lat = 33;
    wait_ov(k);
    chk("to_next", out_result, 64'd20);
    chk("to_sticky", timeout_err, 1);

    // Async reset with a pending product, a stalled entry and the flag set
    push(32'd1, 32'd1);
    chk("pre_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("ar_ov", out_valid, 0);
    chk("ar_en", mult_enable, 0);
    chk("ar_rdy", in_ready, 1);
    chk("ar_busy", busy, 0);
    chk("ar_terr", timeout_err, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Reset during WAIT followed by a stale done
    hang = 1;
    push(32'd9, 32'd9);
    @(negedge clk);
    chk("w_en", mult_enable, 1);
    repeat (10) @(negedge clk);
    chk("w_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("w_rbusy", busy, 0);
    chk("w_ropa", mult_multiplicand, 0);
    @(negedge clk);
    rst = 0;
    repeat (5) @(posedge clk);
    #1 force_done = 1;
    @(posedge clk);
    #1 force_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stale_ov", out_valid, 0);
    end
    chk("stale_busy", busy, 0);

    hang = 0;
    lat = 33;
    push(32'd6, 32'd7);
    wait_ov(k);
    chk("fresh_res", out_result, 64'd42);
    chk("fresh_terr", timeout_err, 0);
    drain();
    chk("fresh_done", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mult_issue.md
Name: mult_issue

Overview:
- Front-end sequencer that sits directly upstream of the sequential 32x32 multiplier `mult` and consumes its result.
- Buffers operand pairs from a valid/ready producer in a small FIFO.
- Issues one pair at a time to `mult` (operands plus enable pulse), waits for `ctrl_done`, and captures the 64-bit product into an output register with valid/ready.
- A watchdog drops an operation whose done never arrives.

Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH.
- DEPTH, 4: operand FIFO entries; power of two, at least 2.
- TIMEOUT, 127: maximum cycles spent in WAIT before the operation is abandoned; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH).
- in_multiplicand  in  WIDTH  operand A.
- in_multiplier  in  WIDTH  operand B.
- out_valid  out  1  out_result holds an unconsumed product.
- out_ready  in  1  consumer accepts the product.
- out_result  out  2*WIDTH  product.
- mult_multiplicand  out  WIDTH  to mult data_multiplicand.
- mult_multiplier  out  WIDTH  to mult data_multiplier.
- mult_enable  out  1  to mult ctrl_enable.
- mult_done  in  1  from mult ctrl_done.
- mult_result  in  2*WIDTH  from mult data_result.
- busy  out  1  high when the state is not IDLE or the FIFO is non-empty.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. FIFO is emptied, the state is IDLE, the watchdog counter is 0, and the operand registers are 0.
- The `mult` unit has no reset. After `rst`, any `mult_done` seen outside WAIT is ignored.
- Input push: occurs on `in_valid && in_ready`. in_ready depends only on count, so a pop in the same cycle does not open a slot while the FIFO is full. Order is FIFO.
- Output handshake: the product transfers on `out_valid && out_ready`. out_valid clears the next cycle unless it is reloaded in that same cycle. out_result is stable while out_valid=1 and out_ready=0.
- State IDLE:
  - Moves to ISSUE when the FIFO is non-empty AND (out_valid=0 OR out_ready=1).
  - On that transition, the FIFO head is registered into mult_multiplicand and mult_multiplier.
- State ISSUE (exactly one cycle):
  - mult_enable=1. Operands are already stable.
  - Always moves to WAIT; the watchdog counter is cleared.
  - A mult_done seen during ISSUE is ignored.
- State WAIT:
  - mult_enable=0. Operand outputs are held constant.
  - The watchdog counter increments each cycle.
  - If mult_done=1: out_result <= mult_result, out_valid <= 1, pop the FIFO, move to IDLE.
  - Else if the counter reaches TIMEOUT: timeout_err <= 1, pop the FIFO (the entry is dropped, no product is produced), move to IDLE.
  - If mult_done arrives in the same cycle the counter reaches TIMEOUT, done wins.
- Latency: for a pair accepted in cycle N with the block idle and the output empty:
  - IDLE decides in N+1.
  - mult_enable is high in N+2.
  - If mult_done is high in cycle D (D > N+2), out_valid is high from D+1.
- No overlap: at most one operation is outstanding at `mult`.
- timeout_err is cleared only by rst.
- Reset mid-operation: state returns to IDLE, the FIFO and out_valid are cleared, and mult_enable is 0 immediately (asynchronous).
- Arithmetic: none in this block. The product is passed through unmodified, full 2*WIDTH bits.
- FIFO pointers: log2(DEPTH) bits with natural wrap. count is log2(DEPTH)+1 bits.

Test Plan:
- Reset: assert rst mid-cycle -> immediately out_valid=0, mult_enable=0, in_ready=1, busy=0, timeout_err=0.
- Single op: push 3, 5 at cycle N; mult model asserts done 33 cycles after enable with result 15 -> mult_enable is a single pulse at N+2, out_result=64'd15, out_valid high until out_ready=1.
- Extremes: push 0xFFFFFFFF x 0xFFFFFFFF, then 0 x 0x12345678 -> out_result=0xFFFFFFFE00000001, then 0, in order.
- Fill and backpressure: hold out_ready=0 and push 6 pairs -> in_ready drops after the 4th buffered entry. Only one mult_enable pulse occurs until the first result is drained. Releasing out_ready yields all results in push order.
- Timeout: model never asserts done -> timeout_err=1 exactly TIMEOUT cycles into WAIT, the entry is dropped, and the next queued pair issues normally and produces the correct product.
- Reset during WAIT, then a stale mult_done pulse 5 cycles later -> out_valid stays 0. A fresh op after reset completes correctly.
